// File: rtl/flash_arbiter_if.sv
// Requester-side and flash_serial-side signals of flash_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the flash.
interface flash_arbiter_if #(
    parameter int BITS       = 8,
    parameter int ADDR_WORDS = 3,
    parameter int LEN_BITS   = 8
);
    logic [1:0]                    in_req;
    logic [1:0]                    in_read;
    logic [2*BITS*ADDR_WORDS-1:0]  in_addr;
    logic [2*LEN_BITS-1:0]         in_len;
    logic [2*BITS-1:0]             in_wdata;
    logic [1:0]                    out_grant;
    logic [1:0]                    out_word_valid;
    logic [BITS-1:0]               out_rdata;
    logic [1:0]                    out_done;
    logic [1:0]                    out_error;
    logic                          out_flash_enable;
    logic                          out_flash_read;
    logic [BITS*ADDR_WORDS-1:0]    out_flash_addr;
    logic [BITS-1:0]               out_flash_data;
    logic [BITS-1:0]               in_flash_data;
    logic                          in_flash_word_finished;
    logic                          in_flash_next_word;

    modport slave (
        input  in_req, in_read, in_addr, in_len, in_wdata,
        input  in_flash_data, in_flash_word_finished, in_flash_next_word,
        output out_grant, out_word_valid, out_rdata, out_done, out_error,
        output out_flash_enable, out_flash_read, out_flash_addr, out_flash_data
    );

    modport master (
        output in_req, in_read, in_addr, in_len, in_wdata,
        output in_flash_data, in_flash_word_finished, in_flash_next_word,
        input  out_grant, out_word_valid, out_rdata, out_done, out_error,
        input  out_flash_enable, out_flash_read, out_flash_addr, out_flash_data
    );
endinterface

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one flash_serial between two requesters, sequencing N-word bursts.
// Define FLASH_ARBITER_TIMEOUT_EN to abort a burst after TIMEOUT cycles without a finished word.
module flash_arbiter #(
    parameter int BITS       = 8,
    parameter int ADDR_WORDS = 3,
    parameter int LEN_BITS   = 8
`ifdef FLASH_ARBITER_TIMEOUT_EN
    , parameter int TIMEOUT  = 27_000_000
`endif
) (
    input logic           in_clk,
    input logic           in_rst,
    flash_arbiter_if.slave bus
);
    localparam int AW = BITS * ADDR_WORDS;

    typedef enum logic [2:0] {IDLE, GRANT, ACTIVE, DRAIN, RELEASE} state_t;
    state_t state, state_next;

    logic                last_grant, g, pick, read_pick, lat_read;
    logic [LEN_BITS-1:0] words_left, len_pick;
    logic [AW-1:0]       lat_addr, addr_pick;
    logic                last_finished, last_next_word, seen_fin;
    logic [1:0]          word_valid_r, g_onehot, grant_c, done_c, error_c;
    logic [BITS-1:0]     rdata_r, wdata_g;
    logic                enable_c, busy, fin_rise, fin_fall, nxt_rise;
    logic                timeout_hit, timed_out;

    assign fin_rise  = bus.in_flash_word_finished & ~last_finished;
    assign fin_fall  = ~bus.in_flash_word_finished & last_finished;
    assign nxt_rise  = bus.in_flash_next_word & ~last_next_word;
    assign g_onehot  = g ? 2'b10 : 2'b01;
    assign wdata_g   = g ? bus.in_wdata[2*BITS-1:BITS] : bus.in_wdata[BITS-1:0];
    assign busy      = (state == GRANT) || (state == ACTIVE) || (state == DRAIN);

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (bus.in_req == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = bus.in_req[1] & ~bus.in_req[0];
        end
        len_pick  = pick ? bus.in_len[2*LEN_BITS-1:LEN_BITS] : bus.in_len[LEN_BITS-1:0];
        addr_pick = pick ? bus.in_addr[2*AW-1:AW] : bus.in_addr[AW-1:0];
        read_pick = bus.in_read[pick];
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enable drops in the same cycle the last word starts, so flash_serial stops after it.
    always_comb begin
        state_next = state;
        enable_c   = 1'b0;
        grant_c    = 2'b00;
        done_c     = 2'b00;
        error_c    = 2'b00;
        case (state)
            IDLE: begin
                if (|bus.in_req) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                grant_c    = g_onehot;
                state_next = ACTIVE;
            end
            ACTIVE: begin
                grant_c  = g_onehot;
                enable_c = 1'b1;
                if (timeout_hit) begin
                    enable_c   = 1'b0;
                    state_next = RELEASE;
                end else if (nxt_rise && (words_left == LEN_BITS'(1))) begin
                    enable_c   = 1'b0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                grant_c = g_onehot;
                if (timeout_hit || (seen_fin && fin_fall)) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (timed_out) begin
                    error_c = g_onehot;
                end else begin
                    done_c = g_onehot;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            last_grant     <= 1'b1;
            g              <= 1'b0;
            words_left     <= '0;
            lat_addr       <= '0;
            lat_read       <= 1'b1;
            last_finished  <= 1'b0;
            last_next_word <= 1'b0;
            seen_fin       <= 1'b0;
            word_valid_r   <= 2'b00;
            rdata_r        <= '0;
        end else begin
            last_finished  <= bus.in_flash_word_finished;
            last_next_word <= bus.in_flash_next_word;
            word_valid_r   <= 2'b00;
            case (state)
                IDLE: begin
                    if (|bus.in_req) begin
                        g          <= pick;
                        words_left <= (len_pick == '0) ? LEN_BITS'(1) : len_pick;
                        lat_addr   <= addr_pick;
                        lat_read   <= read_pick;
                        seen_fin   <= 1'b0;
                    end
                end
                ACTIVE, DRAIN: begin
                    if (fin_rise) begin
                        word_valid_r <= g_onehot;
                        rdata_r      <= bus.in_flash_data;
                        if (words_left != '0) begin
                            words_left <= words_left - LEN_BITS'(1);
                        end
                        if (state == DRAIN) begin
                            seen_fin <= 1'b1;
                        end
                    end
                end
                RELEASE: last_grant <= g;
                default: ;
            endcase
        end
    end

`ifdef FLASH_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    logic          timed_out_r;

    // Watchdog restarts on every finished word; a hit forces Release with an error pulse.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            timer       <= '0;
            timed_out_r <= 1'b0;
        end else if ((state == ACTIVE) || (state == DRAIN)) begin
            timer <= fin_rise ? '0 : timer + TW'(1);
            if (timeout_hit) begin
                timed_out_r <= 1'b1;
            end
        end else begin
            timer <= '0;
            if (state == IDLE) begin
                timed_out_r <= 1'b0;
            end
        end
    end

    assign timeout_hit = ((state == ACTIVE) || (state == DRAIN)) && !fin_rise
                         && (timer >= TW'(TIMEOUT - 1));
    assign timed_out   = timed_out_r;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    assign bus.out_grant        = grant_c;
    assign bus.out_word_valid   = word_valid_r;
    assign bus.out_rdata        = rdata_r;
    assign bus.out_done         = done_c;
    assign bus.out_error        = error_c;
    assign bus.out_flash_enable = enable_c;
    assign bus.out_flash_read   = busy ? lat_read : 1'b1;
    assign bus.out_flash_addr   = busy ? lat_addr : '0;
    assign bus.out_flash_data   = busy ? wdata_g : '0;
endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares one flash_serial instance between two requesters, e.g. a serial dumper reading and a logger writing.
- Requests are granted round-robin.
- The block sequences flash_serial's enable, read and address inputs for a burst of N words.
- Per-word completion is reported back to the granted requester.
- Sits between the user state machines and flash_serial; all on the main clock.

Parameters:
- BITS, 8, flash word width.
- ADDR_WORDS, 3, address width in words; address is BITS*ADDR_WORDS bits.
- LEN_BITS, 8, burst length counter width.
- TIMEOUT, 27_000_000, cycles without a finished word before abort (optional feature only).

Ports:
- in_clk  in  1  main clock.
- in_rst  in  1  reset.
- in_req  in  2  request per requester; held high until out_done.
- in_read  in  2  1 = read burst, 0 = write burst, per requester.
- in_addr  in  2*BITS*ADDR_WORDS  start address per requester; requester i occupies slice i.
- in_len  in  2*LEN_BITS  burst length in words per requester; 0 is treated as 1.
- in_wdata  in  2*BITS  write data per requester.
- out_grant  out  2  one-hot grant.
- out_word_valid  out  2  1-cycle pulse per finished word, to the granted requester.
- out_rdata  out  BITS  read data, valid with out_word_valid.
- out_done  out  2  1-cycle pulse when the burst ends.
- out_error  out  2  1-cycle timeout pulse; constant 0 without the optional feature.
- out_flash_enable, out_flash_read, out_flash_addr, out_flash_data  out  to flash_serial in_enable / in_read / in_addr / in_data.
- in_flash_data  in  BITS  from flash_serial out_data.
- in_flash_word_finished  in  1  from flash_serial out_word_finished.
- in_flash_next_word  in  1  from flash_serial out_next_word.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high, ports named in_clk / in_rst as elsewhere in the codebase.
- Reset values: all outputs 0, out_flash_read=1, state=Idle, last_grant=1 (so requester 0 wins the first tie).
- Edge detection: registered copies of word_finished and next_word.
  - fin_rise = finished & ~last_finished.
  - fin_fall = ~finished & last_finished.
  - nxt_rise = next_word & ~last_next_word.
- Idle:
  - Any in_req high moves to Grant.
  - With both requests high, grant the requester != last_grant.
  - Latch requester index g, words_left = max(in_len[g], 1), and the addr/read of g.
- Grant, 1 cycle: out_grant[g]=1; go to Active.
- Active:
  - out_flash_enable=1; out_flash_read and out_flash_addr from the latched values; out_flash_data = in_wdata[g] (live mux).
  - On nxt_rise with words_left==1: enable drops combinationally in the same cycle; go to Drain.
  - On fin_rise: pulse out_word_valid[g]; out_rdata = in_flash_data, registered, so it appears the cycle after fin_rise together with the pulse; words_left decrements.
  - The requester updates in_wdata after each valid pulse.
- Drain: enable=0; wait for fin_rise (last word, reported as above), then fin_fall; then go to Release.
- Release, 1 cycle:
  - enable=0, out_done[g] pulse, out_grant=0, last_grant=g; go to Idle.
  - The guaranteed enable-low gap lets flash_serial deselect the chip.
- Address: the flash streams sequential words itself; out_flash_addr is held for the whole burst, with no per-word increment in this block.
- Grant stability: the grant is never revoked mid-burst. in_req dropping during Active is ignored until the burst completes.
- Back-to-back: a requester re-requesting in the cycle out_done pulses loses the tie to a waiting peer.
- Reset mid-burst: immediate return to Idle with enable low; no out_done is issued.

Optional Feature:
- Macro: FLASH_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter counts cycles in Active/Drain and resets on fin_rise.
  - Reaching TIMEOUT pulses out_error[g] instead of out_done[g] and forces Release.
- Undefined: no counter; out_error tied to 0; the block may wait forever.

Test Plan:
- Requester 0: read, addr 0x000010, len 3, with a flash model returning 0x41,0x42,0x43 -> three out_word_valid[0] pulses carrying 0x41,0x42,0x43, then out_done[0]; enable low after the third nxt_rise.
- Both requests rise in the same cycle after reset -> grant 0 first, then grant 1; a second simultaneous pair -> grant 1 is not repeated, order alternates 0,1,0,1.
- Requester 1: write len 1, in_wdata 0x5A ('Z') -> out_flash_read=0 and out_flash_data=0x5A while enabled; exactly one out_word_valid[1] pulse, then out_done[1].
- in_len=0 -> behaves exactly like len 1.
- Assert in_rst during the 2nd word of a len-4 burst -> all outputs 0 and out_flash_read=1 within the reset cycle; no out_done; a new request is served normally afterwards.
- With FLASH_ARBITER_TIMEOUT_EN and TIMEOUT=100, flash model never finishes -> out_error[g] pulses at cycle 100, followed by Release and Idle.
